float_mul_arbiter: RTL and testbench
====================================

// Module: float_mul_arbiter
// PURPOSE
//  Shares one multi-cycle float multiplier (req/ack, one-cycle ack+out) among NUM_CLIENTS requesters.
//  Round-robin arbitration; one operation in flight; result routed back with one-cycle per-client ack.
//  Sits between the execution/issue units and the float multiplier core.
//  A watchdog aborts a hung multiplier operation.
// PARAMETERS
//  NUM_CLIENTS     4    number of requesters, >= 2
//  TIMEOUT_CYCLES  64   max cycles in WAIT before abort; must exceed worst-case multiplier latency
//  float_width     32   operand/result width, from shared float package
// PORTS
//  clk          in   1                    clock
//  rst          in   1                    async reset, active low
//  cli_req      in   NUM_CLIENTS          per-client request level; held high until that client's ack
//  cli_a        in   NUM_CLIENTS*32       operand a, client i at [i*32 +: 32]; stable while req high
//  cli_b        in   NUM_CLIENTS*32       operand b, same packing
//  cli_ack      out  NUM_CLIENTS          one-hot, one-cycle result strobe
//  cli_out      out  32                   result, valid only while some cli_ack bit is high
//  cli_err      out  1                    high with cli_ack when result aborted by watchdog
//  mul_req      out  1                    one-cycle request to multiplier
//  mul_a        out  32                   operand a to multiplier, registered
//  mul_b        out  32                   operand b to multiplier, registered
//  mul_ack      in   1                    multiplier done strobe
//  mul_out      in   32                   multiplier result, valid with mul_ack
//  busy         out  1                    high in WAIT and RESP
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; rr pointer 0; watchdog 0.
//    Reset mid-operation abandons the op; the multiplier shares rst.
//  - IDLE: if any cli_req, pick the first requester at or after the pointer, wrapping modulo NUM_CLIENTS.
//    Register grant, mul_a/mul_b <= that client's operands, mul_req <= 1, watchdog <= 0, go WAIT.
//    The pointer updates to grant+1 mod NUM_CLIENTS at the same edge.
//  - WAIT: mul_req is high only in the first WAIT cycle. The watchdog increments each cycle.
//    On mul_ack: cli_out <= mul_out, cli_ack[grant] <= 1, cli_err <= 0, go RESP.
//    If watchdog reaches TIMEOUT_CYCLES-1 without mul_ack: cli_out <= 0, cli_ack[grant] <= 1,
//    cli_err <= 1, go RESP.
//  - RESP: ack/out/err are high for exactly this cycle, then cleared; go IDLE.
//    The granted client drops req at the edge ending RESP.
//    A req still high in the following IDLE counts as a new request.
//  - Latency: req seen in IDLE at cycle t -> mul_req at t+1 -> cli_ack one cycle after mul_ack.
//    Throughput: one op per (multiplier latency + 3) cycles.
//  - mul_ack in IDLE or RESP is ignored (spurious).
//  - A client dropping req while granted: the op completes and its ack is still pulsed.
//  - Simultaneous requests: strict rr order, no starvation. With all clients requesting, each is
//    served once per NUM_CLIENTS ops.
//  - cli_a/cli_b are sampled only at the grant edge; changes afterwards do not affect the op.
//  - X on cli_req or mul_ack in any state is an assertion failure.
// STRUCTURE
//  - Shared float package: float_width/exp/mant constants.
//    Add typedef enum e_mul_arb_state {IDLE, WAIT, RESP}.
//  - Sub-module rr_pick: combinational; inputs req vector and pointer;
//    outputs grant index and a valid flag. Reusable by other shared float units.
//  - Registered outputs only; the watchdog counter is $clog2(TIMEOUT_CYCLES) wide.
// TESTING (bench instantiates float_mul_pipeline as the multiplier)
//  1. Client 0: a=0x40000000 (2.0), b=0x40400000 (3.0).
//     -> one mul_req pulse; cli_ack=4'b0001, cli_out=0x40C00000.
//  2. Clients 1 and 3 request together from reset (pointer 0).
//     -> client 1 served first, then 3; client 3 gets 0x40400000 for 1.5*2.0 (0x3FC00000*0x40000000).
//  3. All 4 clients hold req continuously for 8 ops -> grant order 0,1,2,3,0,1,2,3; each client acked twice.
//  4. Client 2: a=0x00000000, b=0x40400000 -> cli_out=0x00000000, cli_err=0.
//  5. Stub multiplier never acks -> after TIMEOUT_CYCLES: cli_ack for client 0, cli_out=0, cli_err=1;
//     next request is served normally.
//  6. rst low while in WAIT -> all outputs 0 next cycle; after release, a new req completes correctly;
//     a spurious mul_ack injected in IDLE produces no cli_ack.

Source files
------------

// File: rtl/float_mul_arbiter_pkg.sv
// Shared float constants and the state type for the shared-multiplier arbiter.
// Both the arbiter and the round-robin picker import this package.
package float_mul_arbiter_pkg;

    localparam int float_width      = 32;
    localparam int float_exp_width  = 8;
    localparam int float_mant_width = 23;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } e_mul_arb_state;

endpackage

// File: rtl/float_mul_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
// Usable by any shared float unit that needs a fair requester choice.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          valid
);

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        grant = ptr;
        valid = 1'b0;
        for (int off = N - 1; off >= 0; off--) begin
            if (req[(int'(ptr) + off) % N]) begin
                grant = IW'((int'(ptr) + off) % N);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/float_mul_arbiter.sv
// Shares one multi-cycle float multiplier among NUM_CLIENTS requesters, one op in flight,
// round-robin grant, per-client one-cycle ack, and a watchdog that aborts a hung op.
module float_mul_arbiter
    import float_mul_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CLIENTS-1:0]             cli_req,
    input  logic [NUM_CLIENTS*float_width-1:0] cli_a,
    input  logic [NUM_CLIENTS*float_width-1:0] cli_b,
    output logic [NUM_CLIENTS-1:0]             cli_ack,
    output logic [float_width-1:0]             cli_out,
    output logic                               cli_err,
    output logic                               mul_req,
    output logic [float_width-1:0]             mul_a,
    output logic [float_width-1:0]             mul_b,
    input  logic                               mul_ack,
    input  logic [float_width-1:0]             mul_out,
    output logic                               busy
);

    localparam int IW = $clog2(NUM_CLIENTS);
    localparam int WW = $clog2(TIMEOUT_CYCLES);

    e_mul_arb_state          state_reg, state_next;
    logic [IW-1:0]           ptr_reg, ptr_next;
    logic [IW-1:0]           grant_reg, grant_next;
    logic [WW-1:0]           wd_reg, wd_next;
    logic [NUM_CLIENTS-1:0]  ack_reg, ack_next;
    logic [float_width-1:0]  out_reg, out_next;
    logic                    err_reg, err_next;
    logic                    mul_req_reg, mul_req_next;
    logic [float_width-1:0]  mul_a_reg, mul_a_next;
    logic [float_width-1:0]  mul_b_reg, mul_b_next;
    logic                    busy_reg, busy_next;

    logic [IW-1:0]           pick_grant;
    logic                    pick_valid;

    rr_pick #(
        .N  (NUM_CLIENTS),
        .IW (IW)
    ) u_rr_pick (
        .req   (cli_req),
        .ptr   (ptr_reg),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        grant_next   = grant_reg;
        wd_next      = wd_reg;
        ack_next     = '0;
        out_next     = '0;
        err_next     = 1'b0;
        mul_req_next = 1'b0;
        mul_a_next   = mul_a_reg;
        mul_b_next   = mul_b_reg;
        busy_next    = busy_reg;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    grant_next   = pick_grant;
                    mul_a_next   = cli_a[pick_grant*float_width +: float_width];
                    mul_b_next   = cli_b[pick_grant*float_width +: float_width];
                    mul_req_next = 1'b1;
                    wd_next      = '0;
                    ptr_next     = (pick_grant == IW'(NUM_CLIENTS - 1)) ? '0 : pick_grant + 1'b1;
                    busy_next    = 1'b1;
                    state_next   = WAIT;
                end
            end
            WAIT: begin
                wd_next = wd_reg + 1'b1;
                // A real result beats the watchdog if both land on the same edge.
                if (mul_ack) begin
                    out_next            = mul_out;
                    ack_next[grant_reg] = 1'b1;
                    state_next          = RESP;
                end else if (wd_reg == WW'(TIMEOUT_CYCLES - 1)) begin
                    ack_next[grant_reg] = 1'b1;
                    err_next            = 1'b1;
                    state_next          = RESP;
                end
            end
            RESP: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            grant_reg   <= '0;
            wd_reg      <= '0;
            ack_reg     <= '0;
            out_reg     <= '0;
            err_reg     <= 1'b0;
            mul_req_reg <= 1'b0;
            mul_a_reg   <= '0;
            mul_b_reg   <= '0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            grant_reg   <= grant_next;
            wd_reg      <= wd_next;
            ack_reg     <= ack_next;
            out_reg     <= out_next;
            err_reg     <= err_next;
            mul_req_reg <= mul_req_next;
            mul_a_reg   <= mul_a_next;
            mul_b_reg   <= mul_b_next;
            busy_reg    <= busy_next;
        end
    end

    assign cli_ack = ack_reg;
    assign cli_out = out_reg;
    assign cli_err = err_reg;
    assign mul_req = mul_req_reg;
    assign mul_a   = mul_a_reg;
    assign mul_b   = mul_b_reg;
    assign busy    = busy_reg;

    assert property (@(posedge clk) disable iff (!rst) !$isunknown(cli_req));
    assert property (@(posedge clk) disable iff (!rst) !$isunknown(mul_ack));

endmodule

// File: tb/tb_float_mul_arbiter.sv
// Bench for float_mul_arbiter: behavioural multiplier with variable latency or stub mode,
// a vector table, directed corner sequences, and a randomized round-robin scoreboard.
module tb_float_mul_arbiter;

    localparam int NC = 4;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NC-1:0]   cli_req = '0;
    logic [NC*32-1:0] cli_a = '0;
    logic [NC*32-1:0] cli_b = '0;
    logic [NC-1:0]   cli_ack;
    logic [31:0]     cli_out;
    logic            cli_err;
    logic            mul_req;
    logic [31:0]     mul_a;
    logic [31:0]     mul_b;
    logic            mul_ack;
    logic [31:0]     mul_out;
    logic            busy;

    logic            model_ack;
    logic [31:0]     model_out;
    logic            inject_ack = 1'b0;
    logic            stub = 1'b0;
    int              fixed_lat = 3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          client;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic        err;
        string       name;
    } vec_t;

    always #5 clk = ~clk;

    assign mul_ack = model_ack | inject_ack;
    assign mul_out = model_out;

    float_mul_arbiter #(
        .NUM_CLIENTS    (NC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cli_req (cli_req),
        .cli_a   (cli_a),
        .cli_b   (cli_b),
        .cli_ack (cli_ack),
        .cli_out (cli_out),
        .cli_err (cli_err),
        .mul_req (mul_req),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .mul_ack (mul_ack),
        .mul_out (mul_out),
        .busy    (busy)
    );

    // Truncating single-precision multiply for normal numbers and zero.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] p;
        logic [22:0] m;
        s = a[31] ^ b[31];
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            e = e + 1;
            m = p[46:24];
        end else begin
            m = p[45:23];
        end
        return {s, 8'(e), m};
    endfunction

    function automatic logic [31:0] rand_float();
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        s = 1'($urandom_range(0, 1));
        e = 8'($urandom_range(100, 154));
        m = 23'($urandom);
        return {s, e, m};
    endfunction

    function automatic int rr_expect(input logic [NC-1:0] req, input int ptr);
        for (int off = 0; off < NC; off++) begin
            if (req[(ptr + off) % NC]) return (ptr + off) % NC;
        end
        return -1;
    endfunction

    // Multiplier model: accepts mul_req, answers after a fixed or random latency.
    logic        m_busy;
    int          m_cnt;
    logic [31:0] m_a, m_b;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy    <= 1'b0;
            m_cnt     <= 0;
            m_a       <= '0;
            m_b       <= '0;
            model_ack <= 1'b0;
            model_out <= '0;
        end else begin
            model_ack <= 1'b0;
            if (mul_req && !stub) begin
                m_busy <= 1'b1;
                m_cnt  <= (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
                m_a    <= mul_a;
                m_b    <= mul_b;
            end else if (m_busy) begin
                if (m_cnt <= 1) begin
                    model_ack <= 1'b1;
                    model_out <= fmul(m_a, m_b);
                    m_busy    <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_quiet(input string nm);
        chk({nm, "_ack_err_req_busy"}, {cli_ack, cli_err, mul_req, busy}, 64'd0);
        chk({nm, "_cli_out"}, cli_out, 64'd0);
        chk({nm, "_mul_a"}, mul_a, 64'd0);
        chk({nm, "_mul_b"}, mul_b, 64'd0);
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        cli_req    = '0;
        inject_ack = 1'b0;
        stub       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // One client request, checked from request to the idle cycle after its ack.
    task automatic run_op(input int c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eo, input logic ee, input string nm, input int budget);
        int   pulses = 0;
        int   reqc = -1;
        int   ackc = -1;
        logic got = 1'b0;
        logic pm = 1'b0;
        cli_a[c*32 +: 32] = a;
        cli_b[c*32 +: 32] = b;
        cli_req[c] = 1'b1;
        for (int k = 0; k < budget && !got; k++) begin
            @(posedge clk);
            #1;
            if (mul_req) begin
                pulses++;
                reqc = k;
                chk({nm, "_mul_a"}, mul_a, a);
                chk({nm, "_mul_b"}, mul_b, b);
            end
            if (cli_ack != '0) begin
                got  = 1'b1;
                ackc = k;
                $display("op %s: client %0d ack %b out %h err %b", nm, c, cli_ack, cli_out, cli_err);
                chk({nm, "_ack"}, cli_ack, 64'(1 << c));
                chk({nm, "_out"}, cli_out, eo);
                chk({nm, "_err"}, cli_err, ee);
                chk({nm, "_busy"}, busy, 1);
                if (ee) chk({nm, "_timeout_cycles"}, 64'(ackc - reqc), TO);
                else    chk({nm, "_ack_after_mul_ack"}, pm, 1);
                cli_req[c] = 1'b0;
            end
            pm = mul_ack;
        end
        chk({nm, "_acked"}, got, 1);
        chk({nm, "_mul_req_pulses"}, pulses, 1);
        @(posedge clk);
        #1;
        chk({nm, "_ack_cleared"}, {cli_ack, cli_err, busy}, 64'd0);
        chk({nm, "_out_cleared"}, cli_out, 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        vec_t        vecs[5];
        int          got;
        int          n;
        int          cnt[NC];
        logic        seen;
        logic [31:0] opa[NC];
        logic [31:0] opb[NC];
        logic [NC-1:0] snap;
        int          ptr_m;
        int          exp_g;
        int          g;
        logic        exp_valid;
        logic        prev_mack;
        int          acked_c;

        vecs[0] = '{0, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, "t1_c0_2x3"};
        vecs[1] = '{2, 32'h00000000, 32'h40400000, 32'h00000000, 1'b0, "t4_c2_0x3"};
        vecs[2] = '{1, 32'h40800000, 32'h3F000000, 32'h40000000, 1'b0, "v_c1_4xhalf"};
        vecs[3] = '{3, 32'hBFC00000, 32'h40000000, 32'hC0400000, 1'b0, "v_c3_neg"};
        vecs[4] = '{0, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, "v_c0_1x1"};

        // Reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        rst = 1'b1;

        // Vector table, single requester each
        for (int i = 0; i < 5; i++)
            run_op(vecs[i].client, vecs[i].a, vecs[i].b, vecs[i].out, vecs[i].err, vecs[i].name, 40);

        // Clients 1 and 3 together from reset: 1 first, then 3
        do_reset();
        cli_a[1*32 +: 32] = 32'h40800000;
        cli_b[1*32 +: 32] = 32'h3F000000;
        cli_a[3*32 +: 32] = 32'h3FC00000;
        cli_b[3*32 +: 32] = 32'h40000000;
        cli_req = 4'b1010;
        got = 0;
        for (int k = 0; k < 200 && got < 2; k++) begin
            @(posedge clk);
            #1;
            if (cli_ack != '0) begin
                $display("op t2: ack %b out %h err %b", cli_ack, cli_out, cli_err);
                if (got == 0) begin
                    chk("t2_first_ack", cli_ack, 4'b0010);
                    chk("t2_first_out", cli_out, 32'h40000000);
                end else begin
                    chk("t2_second_ack", cli_ack, 4'b1000);
                    chk("t2_second_out", cli_out, 32'h40400000);
                end
                cli_req = cli_req & ~cli_ack;
                got++;
            end
        end
        chk("t2_ops", got, 2);

        // All four hold req for 8 ops
        do_reset();
        for (int i = 0; i < NC; i++) begin
            cli_a[i*32 +: 32] = 32'h3F800000 + 32'(i << 21);
            cli_b[i*32 +: 32] = 32'h40000000 + 32'(i << 20);
            cnt[i] = 0;
        end
        cli_req = '1;
        n = 0;
        for (int k = 0; k < 400 && n < 8; k++) begin
            @(posedge clk);
            #1;
            if (cli_ack != '0) begin
                $display("op t3 #%0d: ack %b out %h", n, cli_ack, cli_out);
                chk("t3_order", cli_ack, 64'(1 << (n % NC)));
                chk("t3_out", cli_out, fmul(cli_a[(n % NC)*32 +: 32], cli_b[(n % NC)*32 +: 32]));
                for (int i = 0; i < NC; i++) if (cli_ack[i]) cnt[i]++;
                n++;
                if (n == 8) cli_req = '0;
            end
        end
        chk("t3_ops", n, 8);
        for (int i = 0; i < NC; i++) chk($sformatf("t3_count_c%0d", i), cnt[i], 2);

        // Watchdog abort, then a normal op
        do_reset();
        stub = 1'b1;
        run_op(0, 32'h40000000, 32'h40400000, 32'h0, 1'b1, "t5_timeout", TO + 20);
        stub = 1'b0;
        run_op(0, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, "t5_after", 40);

        // Reset during WAIT, recovery, spurious mul_ack in IDLE
        do_reset();
        fixed_lat = 20;
        cli_a[1*32 +: 32] = 32'h40000000;
        cli_b[1*32 +: 32] = 32'h40400000;
        cli_req[1] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clk);
            #1;
            seen = mul_req;
        end
        chk("t6_grant_seen", seen, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_busy_in_wait", busy, 1);
        rst = 1'b0;
        cli_req = '0;
        @(posedge clk);
        #1;
        check_quiet("t6_reset");
        rst = 1'b1;
        fixed_lat = 3;
        run_op(1, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, "t6_recover", 40);
        inject_ack = 1'b1;
        @(posedge clk);
        #1;
        inject_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t6_spurious_no_ack", {cli_ack, busy}, 64'd0);
            @(posedge clk);
            #1;
        end

        // Randomized traffic against a round-robin scoreboard
        do_reset();
        fixed_lat = 0;
        ptr_m = 0;
        exp_g = 0;
        exp_valid = 1'b0;
        prev_mack = 1'b0;
        snap = '0;
        n = 0;
        for (int i = 0; i < NC; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        for (int cyc = 0; cyc < 6000 && n < 40; cyc++) begin
            @(posedge clk);
            #1;
            acked_c = -1;
            if (mul_req) begin
                g = rr_expect(snap, ptr_m);
                chk("rand_grant_had_req", (g >= 0), 1);
                if (g >= 0) begin
                    chk("rand_mul_a", mul_a, opa[g]);
                    chk("rand_mul_b", mul_b, opb[g]);
                    exp_g = g;
                    exp_valid = 1'b1;
                    ptr_m = (g + 1) % NC;
                end
            end
            if (cli_ack != '0) begin
                $display("op rand #%0d: ack %b out %h err %b", n, cli_ack, cli_out, cli_err);
                chk("rand_ack_expected", exp_valid, 1);
                chk("rand_ack_client", cli_ack, 64'(1 << exp_g));
                chk("rand_out", cli_out, fmul(opa[exp_g], opb[exp_g]));
                chk("rand_err", cli_err, 0);
                chk("rand_ack_after_mul_ack", prev_mack, 1);
                cli_req[exp_g] = 1'b0;
                acked_c = exp_g;
                exp_valid = 1'b0;
                n++;
            end
            for (int i = 0; i < NC; i++) begin
                if (!cli_req[i] && i != acked_c && $urandom_range(0, 3) == 0) begin
                    opa[i] = rand_float();
                    opb[i] = rand_float();
                    cli_a[i*32 +: 32] = opa[i];
                    cli_b[i*32 +: 32] = opb[i];
                    cli_req[i] = 1'b1;
                end
            end
            snap = cli_req;
            prev_mack = mul_ack;
        end
        chk("rand_ops", n, 40);
        cli_req = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
